set_pattern_sequencer: RTL

- Upstream driver and result collector for the SET candidate-counting engine.
- Walks a pattern memory of circle centres and radii, and issues each pattern to SET with a one-cycle en pulse once SET is not busy.
- Waits for SET's valid, then writes the returned candidate count into a result port, one entry per pattern.
- Used on-chip as the self-run front end of SET and as the stimulus source for SET regression.

---
 rtl/set_pattern_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/set_pattern_sequencer.sv
// Front-end sequencer for the SET candidate-counting engine: fetches each pattern,
// issues it to SET with a one-cycle en pulse, and writes back one result per pattern.
module set_pattern_sequencer #(
    parameter int NUM_PAT  = 64,
    parameter int ADDR_W   = 6,
    parameter int MAX_WAIT = 4095
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode_sel,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [23:0]       pat_central,
    input  logic [11:0]       pat_radius,
    output logic              en,
    output logic [23:0]       central,
    output logic [11:0]       radius,
    output logic [1:0]        mode,
    input  logic              busy,
    input  logic              valid,
    input  logic [7:0]        candidate,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [7:0]        res_data,
    output logic              timeout,
    output logic              done,
    output logic [ADDR_W-1:0] pat_idx
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PAT - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH      = 3'd1;
    localparam logic [2:0] S_LOAD       = 3'd2;
    localparam logic [2:0] S_WAIT_IDLE  = 3'd3;
    localparam logic [2:0] S_ISSUE      = 3'd4;
    localparam logic [2:0] S_WAIT_VALID = 3'd5;
    localparam logic [2:0] S_STORE      = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] pat_idx_q, pat_idx_d;
    logic [ADDR_W-1:0] pat_addr_q, pat_addr_d;
    logic [23:0]       central_q, central_d;
    logic [11:0]       radius_q, radius_d;
    logic [1:0]        mode_q, mode_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]        res_data_q, res_data_d;
    logic [ADDR_W-1:0] res_addr_q, res_addr_d;
    logic              timeout_q, timeout_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              res_we_q, res_we_d;

    // Next-state and next-output logic; en and res_we are decoded from the state being entered
    always_comb begin
        state_d    = state_q;
        pat_idx_d  = pat_idx_q;
        pat_addr_d = pat_addr_q;
        central_d  = central_q;
        radius_d   = radius_q;
        mode_d     = mode_q;
        wait_cnt_d = wait_cnt_q;
        res_data_d = res_data_q;
        res_addr_d = res_addr_q;
        timeout_d  = timeout_q;
        done_d     = done_q;
        en_d       = 1'b0;
        res_we_d   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mode_d     = mode_sel;
                    timeout_d  = 1'b0;
                    done_d     = 1'b0;
                    pat_idx_d  = {ADDR_W{1'b0}};
                    pat_addr_d = {ADDR_W{1'b0}};
                    state_d    = S_FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                central_d = pat_central;
                radius_d  = pat_radius;
                state_d   = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!busy) begin
                    en_d    = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = {CNT_W{1'b0}};
                state_d    = S_WAIT_VALID;
            end
            S_WAIT_VALID: begin
                // A valid arriving on the last counted cycle still wins over the timeout
                if (valid) begin
                    res_data_d = candidate;
                    res_addr_d = pat_idx_q;
                    res_we_d   = 1'b1;
                    state_d    = S_STORE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    res_data_d = 8'hFF;
                    res_addr_d = pat_idx_q;
                    res_we_d   = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = S_STORE;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_STORE: begin
                if (pat_idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    pat_idx_d  = pat_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    pat_addr_d = pat_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_d    = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything at once, aborting any pulse in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pat_idx_q  <= {ADDR_W{1'b0}};
            pat_addr_q <= {ADDR_W{1'b0}};
            central_q  <= 24'h000000;
            radius_q   <= 12'h000;
            mode_q     <= 2'b00;
            wait_cnt_q <= {CNT_W{1'b0}};
            res_data_q <= 8'h00;
            res_addr_q <= {ADDR_W{1'b0}};
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
            en_q       <= 1'b0;
            res_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_idx_q  <= pat_idx_d;
            pat_addr_q <= pat_addr_d;
            central_q  <= central_d;
            radius_q   <= radius_d;
            mode_q     <= mode_d;
            wait_cnt_q <= wait_cnt_d;
            res_data_q <= res_data_d;
            res_addr_q <= res_addr_d;
            timeout_q  <= timeout_d;
            done_q     <= done_d;
            en_q       <= en_d;
            res_we_q   <= res_we_d;
        end
    end

    assign pat_addr = pat_addr_q;
    assign en       = en_q;
    assign central  = central_q;
    assign radius   = radius_q;
    assign mode     = mode_q;
    assign res_we   = res_we_q;
    assign res_addr = res_addr_q;
    assign res_data = res_data_q;
    assign timeout  = timeout_q;
    assign done     = done_q;
    assign pat_idx  = pat_idx_q;

endmodule
